negate_serial: RTL and testbench

//  Multi-cycle, parametrised two's-complement negate/abs/pass unit with a start/done handshake.

---
 rtl/negate_pkg.sv | 21 ++
 rtl/negate_serial_if.sv | 30 +++
 rtl/negate_digit.sv | 27 ++
 rtl/negate_serial.sv | 144 ++++++++++++++
 tb/tb_negate_serial.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/negate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : negate_pkg
//  Description : Shared constants for the serial negate/abs/pass unit:
//                operation mode codes and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package negate_pkg;

  // Operation select; 2'b11 is reserved and behaves as pass.
  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;

  // Controller state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : negate_pkg
`default_nettype wire

// File: rtl/negate_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : negate_serial_if
//  Description : Start/done request bundle for the serial negate unit.
//                master = requester, slave = negate_serial.
//  Revision    : 1.0 - initial release
// ============================================================================
interface negate_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             ovf;

  modport master (
    output start, mode, A,
    input  busy, done, out, zero, ovf
  );

  modport slave (
    input  start, mode, A,
    output busy, done, out, zero, ovf
  );
endinterface : negate_serial_if
`default_nettype wire

// File: rtl/negate_digit.sv
`default_nettype none
// ============================================================================
//  Module      : negate_digit
//  Description : One digit slice of the serial adder: optionally inverts the
//                operand digit and adds the incoming carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module negate_digit #(
  parameter int DIGIT = 4
) (
  input  wire logic [DIGIT-1:0] a,
  input  wire logic             inv,
  input  wire logic             cin,
  output logic      [DIGIT-1:0] s,
  output logic                  cout
);

  logic [DIGIT-1:0] w_opnd;

  // Conditional invert followed by carry-in increment; carry-out is the MSB.
  always_comb begin
    w_opnd    = inv ? ~a : a;
    {cout, s} = {1'b0, w_opnd} + {{DIGIT{1'b0}}, cin};
  end

endmodule : negate_digit
`default_nettype wire

// File: rtl/negate_serial.sv
`default_nettype none
// ============================================================================
//  Module      : negate_serial
//  Description : Multi-cycle two's-complement negate / abs / pass unit.
//                Processes DIGIT bits per clock, LSB digit first, and reports
//                result, zero and overflow flags with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module negate_serial
  import negate_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  negate_serial_if.slave bus
);

  localparam int             c_n        = WIDTH / DIGIT;
  localparam int             c_cw       = $clog2(c_n + 1);
  localparam logic [c_cw-1:0] c_last_cnt = c_cw'(c_n - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [c_cw-1:0]  r_cnt;
  logic             r_carry;
  logic             r_neg;
  logic             r_a_msb;
  logic             r_a_lowz;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_nxt;
  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_neg_in;
  logic             w_accept;
  logic             w_step;
  logic             w_busy_d;
  logic             w_done_d;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_ovf;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: start only matters in IDLE; DONE always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == c_last_cnt) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM decode: accept/step strobes and the pre-register busy/done values.
  always_comb begin
    w_accept = (r_state == ST_IDLE) && bus.start;
    w_step   = (r_state == ST_RUN);
    w_busy_d = (r_state == ST_RUN);
    w_done_d = (r_state == ST_DONE);
  end

  // Abs only inverts a negative operand; reserved mode 11 falls to pass.
  assign w_neg_in = (bus.mode == MODE_NEG) ||
                    ((bus.mode == MODE_ABS) && bus.A[WIDTH-1]);

  negate_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (r_opnd[DIGIT-1:0]),
    .inv  (r_neg),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // New digit enters at the top so the LSB digit ends in the bottom slot.
  generate
    if (DIGIT == WIDTH) begin : g_res_single
      assign w_res_nxt = w_s;
    end else begin : g_res_shift
      assign w_res_nxt = {w_s, r_res[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Datapath: latch operand on accept, then consume one digit per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_neg    <= 1'b0;
      r_a_msb  <= 1'b0;
      r_a_lowz <= 1'b0;
      r_opnd   <= '0;
      r_res    <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_carry  <= w_neg_in;
      r_neg    <= w_neg_in;
      r_a_msb  <= bus.A[WIDTH-1];
      r_a_lowz <= (bus.A[WIDTH-2:0] == '0);
      r_opnd   <= bus.A;
    end else if (w_step) begin
      r_cnt    <= r_cnt + c_cw'(1);
      r_carry  <= w_cout;
      r_opnd   <= r_opnd >> DIGIT;
      r_res    <= w_res_nxt;
    end
  end

  // Registered outputs; result and flags load once and hold until next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_out  <= '0;
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_busy <= w_busy_d;
      r_done <= w_done_d;
      if (w_done_d) begin
        r_out  <= r_res;
        r_zero <= (r_res == '0);
        r_ovf  <= r_neg && r_a_msb && r_res[WIDTH-1] && r_a_lowz;
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.out  = r_out;
  assign bus.zero = r_zero;
  assign bus.ovf  = r_ovf;

endmodule : negate_serial
`default_nettype wire

// File: tb/tb_negate_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_negate_serial
//  Description : Directed self-checking bench for negate_serial with three
//                parameter sets (32/4, 32/32, 8/2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_negate_serial;
  import negate_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  negate_serial_if #(.WIDTH(32)) bus0 ();
  negate_serial_if #(.WIDTH(32)) bus1 ();
  negate_serial_if #(.WIDTH(8))  bus2 ();

  negate_serial #(.WIDTH(32), .DIGIT(4))  u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  negate_serial #(.WIDTH(32), .DIGIT(32)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  negate_serial #(.WIDTH(8),  .DIGIT(2))  u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation on the 32/4 instance, observed for 12 cycles after accept.
  task automatic op0(input logic [1:0] m, input logic [31:0] a, input bit disturb,
                     output int busy_n, output int done_n, output int done_at,
                     output logic [31:0] res, output logic z, output logic o);
    busy_n = 0; done_n = 0; done_at = -1; res = 'x; z = 1'bx; o = 1'bx;
    bus0.start = 1'b1; bus0.mode = m; bus0.A = a;
    @(posedge clk); #1;
    bus0.start = 1'b0; bus0.A = 32'hDEAD_BEEF;
    for (int i = 1; i <= 12; i++) begin
      if (disturb) begin
        bus0.start = (i <= 9);
        bus0.mode  = MODE_PASS;
        bus0.A     = ~a;
      end
      @(posedge clk); #1;
      if (bus0.busy) busy_n++;
      if (bus0.done) begin
        done_n++; done_at = i; res = bus0.out; z = bus0.zero; o = bus0.ovf;
      end
    end
    bus0.start = 1'b0;
  endtask

  int          bn, dn, da, d1, d2;
  logic [31:0] res;
  logic        z, o;

  initial begin
    rst = 1'b1;
    bus0.start = 0; bus0.mode = 0; bus0.A = 0;
    bus1.start = 0; bus1.mode = 0; bus1.A = 0;
    bus2.start = 0; bus2.mode = 0; bus2.A = 0;
    @(posedge clk); #1;
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_done", 32'(bus0.done), 0);
    chk("rst_out",  bus0.out, 0);
    chk("rst_zero", 32'(bus0.zero), 0);
    chk("rst_ovf",  32'(bus0.ovf), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // negate 0
    op0(MODE_NEG, 32'h0, 0, bn, dn, da, res, z, o);
    chk("neg0_busy_cycles", 32'(bn), 8);
    chk("neg0_done_count",  32'(dn), 1);
    chk("neg0_latency",     32'(da), 9);
    chk("neg0_out",  res, 32'h0);
    chk("neg0_zero", 32'(z), 1);
    chk("neg0_ovf",  32'(o), 0);

    op0(MODE_NEG, 32'h5, 0, bn, dn, da, res, z, o);
    chk("neg5_out",  res, 32'hFFFF_FFFB);
    chk("neg5_zero", 32'(z), 0);
    chk("neg5_ovf",  32'(o), 0);
    chk("neg5_hold", bus0.out, 32'hFFFF_FFFB);
    chk("neg5_done_low", 32'(bus0.done), 0);

    op0(MODE_NEG, 32'hFFFF_FFFF, 0, bn, dn, da, res, z, o);
    chk("negm1_out", res, 32'h1);
    chk("negm1_zero", 32'(z), 0);
    chk("negm1_ovf", 32'(o), 0);

    op0(MODE_NEG, 32'h8000_0000, 0, bn, dn, da, res, z, o);
    chk("negmin_out", res, 32'h8000_0000);
    chk("negmin_ovf", 32'(o), 1);

    op0(MODE_ABS, 32'h8000_0000, 0, bn, dn, da, res, z, o);
    chk("absmin_out", res, 32'h8000_0000);
    chk("absmin_ovf", 32'(o), 1);

    op0(MODE_ABS, 32'hFFFF_FFF9, 0, bn, dn, da, res, z, o);
    chk("absm7_out", res, 32'h7);
    chk("absm7_ovf", 32'(o), 0);

    op0(MODE_ABS, 32'h7, 0, bn, dn, da, res, z, o);
    chk("abs7_out", res, 32'h7);
    chk("abs7_ovf", 32'(o), 0);

    op0(MODE_PASS, 32'h8000_0000, 0, bn, dn, da, res, z, o);
    chk("passmin_out", res, 32'h8000_0000);
    chk("passmin_ovf", 32'(o), 0);

    op0(2'b11, 32'h1234, 0, bn, dn, da, res, z, o);
    chk("mode3_out", res, 32'h1234);

    // start pulses and operand changes while busy / in DONE are ignored
    op0(MODE_NEG, 32'h10, 1, bn, dn, da, res, z, o);
    chk("dist_out",        res, 32'hFFFF_FFF0);
    chk("dist_done_count", 32'(dn), 1);
    chk("dist_busy",       32'(bn), 8);
    chk("dist_latency",    32'(da), 9);

    // asynchronous reset in RUN cycle 4
    bus0.start = 1'b1; bus0.mode = MODE_NEG; bus0.A = 32'h1234_5678;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 32'(bus0.busy), 1);
    rst = 1'b1; #1;
    chk("arst_busy", 32'(bus0.busy), 0);
    chk("arst_out",  bus0.out, 0);
    chk("arst_done", 32'(bus0.done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus0.done || bus0.busy) dn++;
    end
    chk("arst_no_done", 32'(dn), 0);
    op0(MODE_NEG, 32'h1, 0, bn, dn, da, res, z, o);
    chk("post_rst_neg1", res, 32'hFFFF_FFFF);

    // start held high: one accept per return to IDLE (every N+2 clocks)
    bus0.start = 1'b1; bus0.mode = MODE_NEG; bus0.A = 32'h3;
    dn = 0; d1 = -1; d2 = -1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus0.done) begin
        dn++;
        if (d1 < 0) d1 = i; else d2 = i;
      end
    end
    bus0.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("held_done_count", 32'(dn), 2);
    chk("held_first_done", 32'(d1), 9);
    chk("held_period",     32'(d2 - d1), 10);
    chk("held_out",        bus0.out, 32'hFFFF_FFFD);

    // DIGIT == WIDTH: single RUN cycle
    bus1.start = 1'b1; bus1.mode = MODE_NEG; bus1.A = 32'h5;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    da = -1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (bus1.done) da = i;
    end
    chk("d32_latency", 32'(da), 2);
    chk("d32_out", bus1.out, 32'hFFFF_FFFB);

    // WIDTH = 8, DIGIT = 2
    bus2.start = 1'b1; bus2.mode = MODE_NEG; bus2.A = 8'h80;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    da = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus2.done) da = i;
    end
    chk("w8_latency", 32'(da), 5);
    chk("w8_out", 32'(bus2.out), 32'h80);
    chk("w8_ovf", 32'(bus2.ovf), 1);
    chk("w8_zero", 32'(bus2.zero), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_negate_serial
`default_nettype wire
